// File: rtl/wb_arb2_rr.sv
// wb_arb2_rr: two-master round-robin Wishbone classic arbiter.
// Define WB_ARB2_WATCHDOG_EN to add the hung-transfer watchdog and ABORT state.
module wb_arb2_rr #(
    parameter int unsigned C_TIMEOUT = 256
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,
    output logic [1:0]  gnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
`ifdef WB_ARB2_WATCHDOG_EN
        , ABORT = 2'd3
`endif
    } state_t;

    state_t state;
    state_t state_nx;
    logic   last;
    logic   last_nx;

`ifdef WB_ARB2_WATCHDOG_EN
    localparam logic [15:0] TMO_LAST = 16'(C_TIMEOUT - 1);

    logic [15:0] cnt;
    logic        wd_hit;

    assign wd_hit = (cnt == TMO_LAST) && s_stb_o && !s_ack_i && !s_err_i;

    // count consecutive unanswered strobe cycles within one tenure
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            cnt <= 16'd0;
        end else if ((state == OWN0 || state == OWN1) && state_nx == state &&
                     s_stb_o && !s_ack_i && !s_err_i) begin
            cnt <= cnt + 16'd1;
        end else begin
            cnt <= 16'd0;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = (C_TIMEOUT != 0);
`endif

    // state and round-robin history registers
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nx;
            last  <= last_nx;
        end
    end

    // arbitration and tenure release
    always_comb begin
        state_nx = state;
        last_nx  = last;
        unique case (state)
            IDLE: begin
                if (m0_cyc_i && (!m1_cyc_i || last)) begin
                    state_nx = OWN0;
                    last_nx  = 1'b0;
                end else if (m1_cyc_i) begin
                    state_nx = OWN1;
                    last_nx  = 1'b1;
                end
            end
            OWN0: begin
                if (!m0_cyc_i) state_nx = IDLE;
`ifdef WB_ARB2_WATCHDOG_EN
                else if (wd_hit) state_nx = ABORT;
`endif
            end
            OWN1: begin
                if (!m1_cyc_i) state_nx = IDLE;
`ifdef WB_ARB2_WATCHDOG_EN
                else if (wd_hit) state_nx = ABORT;
`endif
            end
            default: state_nx = IDLE;
        endcase
    end

    // bus mux: owner sees the slave, everyone else sees zeros
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = 4'd0;
        s_adr_o  = 32'd0;
        s_dat_o  = 32'd0;
        m0_dat_o = 32'd0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_dat_o = 32'd0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        gnt_o    = 2'b00;
        unique case (state)
            OWN0: begin
                gnt_o    = 2'b01;
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_dat_o = s_dat_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i;
            end
            OWN1: begin
                gnt_o    = 2'b10;
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_dat_o = s_dat_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i;
            end
`ifdef WB_ARB2_WATCHDOG_EN
            ABORT: begin
                gnt_o    = last ? 2'b10 : 2'b01;
                m0_err_o = !last;
                m1_err_o = last;
            end
`endif
            default: begin
                gnt_o = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_arb2_rr.sv
// tb_wb_arb2_rr: random + directed bench for wb_arb2_rr.
// Watchdog cases follow WB_ARB2_WATCHDOG_EN; the DUT runs with C_TIMEOUT=8.
module tb_wb_arb2_rr;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc [2];
    logic        stb [2];
    logic        we  [2];
    logic [3:0]  sel [2];
    logic [31:0] adr [2];
    logic [31:0] wdat[2];
    logic [31:0] m0_dat, m1_dat;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic        s_cyc, s_stb, s_we;
    logic [3:0]  s_sel;
    logic [31:0] s_adr, s_dat_o, s_dat_i;
    logic        s_ack, s_err;
    logic [1:0]  gnt;

    int checks = 0;
    int fails  = 0;

    // behavioural model: who owns the bus, abort cycle, last winner
    int own   = -1;
    bit ab    = 1'b0;
    int lastw = 1;
    int hung  = 0;

    logic [140:0] act_vec;

    wb_arb2_rr #(.C_TIMEOUT(TMO)) dut (
        .wb_clk_i(clk),     .wb_rst_i(rst_n),
        .m0_cyc_i(cyc[0]),  .m0_stb_i(stb[0]),  .m0_we_i(we[0]),
        .m0_sel_i(sel[0]),  .m0_adr_i(adr[0]),  .m0_dat_i(wdat[0]),
        .m0_dat_o(m0_dat),  .m0_ack_o(m0_ack),  .m0_err_o(m0_err),
        .m1_cyc_i(cyc[1]),  .m1_stb_i(stb[1]),  .m1_we_i(we[1]),
        .m1_sel_i(sel[1]),  .m1_adr_i(adr[1]),  .m1_dat_i(wdat[1]),
        .m1_dat_o(m1_dat),  .m1_ack_o(m1_ack),  .m1_err_o(m1_err),
        .s_cyc_o(s_cyc),    .s_stb_o(s_stb),    .s_we_o(s_we),
        .s_sel_o(s_sel),    .s_adr_o(s_adr),    .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i),  .s_ack_i(s_ack),    .s_err_i(s_err),
        .gnt_o(gnt)
    );

    assign act_vec = {gnt, s_cyc, s_stb, s_we, s_sel, s_adr, s_dat_o,
                      m0_dat, m0_ack, m0_err, m1_dat, m1_ack, m1_err};

    initial forever #5 clk = ~clk;

    // model update: one step per clock, asynchronous reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own = -1; ab = 1'b0; lastw = 1; hung = 0;
        end else if (ab) begin
            ab = 1'b0; own = -1; hung = 0;
        end else if (own < 0) begin
            if (cyc[0] && cyc[1]) own = (lastw == 1) ? 0 : 1;
            else if (cyc[0]) own = 0;
            else if (cyc[1]) own = 1;
            if (own >= 0) lastw = own;
            hung = 0;
        end else if (!cyc[own]) begin
            own = -1; hung = 0;
        end else if (stb[own] && !s_ack && !s_err) begin
            hung = hung + 1;
`ifdef WB_ARB2_WATCHDOG_EN
            if (hung == TMO) begin
                ab = 1'b1; hung = 0;
            end
`endif
        end else begin
            hung = 0;
        end
    end

    function automatic logic [140:0] model_out();
        logic [1:0]  g;
        logic        sc, ss, sw;
        logic [3:0]  sl;
        logic [31:0] sa, sd, d0, d1;
        logic        a0, e0, a1, e1;
        g = 2'b00; sc = 0; ss = 0; sw = 0; sl = 0; sa = 0; sd = 0;
        d0 = 0; d1 = 0; a0 = 0; e0 = 0; a1 = 0; e1 = 0;
        if (own >= 0) begin
            g = (own == 0) ? 2'b01 : 2'b10;
            if (ab) begin
                if (own == 0) e0 = 1'b1; else e1 = 1'b1;
            end else begin
                sc = cyc[own]; ss = stb[own]; sw = we[own];
                sl = sel[own]; sa = adr[own]; sd = wdat[own];
                if (own == 0) begin
                    d0 = s_dat_i; a0 = s_ack; e0 = s_err;
                end else begin
                    d1 = s_dat_i; a1 = s_ack; e1 = s_err;
                end
            end
        end
        return {g, sc, ss, sw, sl, sa, sd, d0, a0, e0, d1, a1, e1};
    endfunction

    task automatic chk(input string nm, input logic [159:0] act,
                       input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic masters_off();
        for (int m = 0; m < 2; m++) begin
            cyc[m] = 0; stb[m] = 0; we[m] = 0;
            sel[m] = 0; adr[m] = 0; wdat[m] = 0;
        end
    endtask

    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_zero", 160'(act_vec), 160'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    logic [1:0] gseq[$];
    logic [1:0] prev_g;
    int         drop[2];

    initial begin
        masters_off();
        s_dat_i = 0; s_ack = 0; s_err = 0;

        fork
            forever begin
                @(negedge clk);
                chk("model", 160'(act_vec), 160'(model_out()));
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 160'(act_vec), 160'd0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("idle_gnt", 160'(gnt), 160'd0);

        // m0 single write, slave acks two cycles into the strobe
        cyc[0] = 1; stb[0] = 1; we[0] = 1;
        adr[0] = 32'h0; wdat[0] = 32'hEEEEEEEE; sel[0] = 4'hE;
        tick();
        chk("wr_gnt", 160'(gnt), 160'h1);
        chk("wr_mirror", 160'({s_cyc, s_stb, s_we, s_sel, s_adr, s_dat_o}),
            160'({3'b111, 4'hE, 32'h0, 32'hEEEEEEEE}));
        tick();
        tick();
        s_ack = 1;
        #1;
        chk("wr_ack", 160'({m0_ack, m1_ack}), 160'b10);
        tick();
        s_ack = 0; masters_off();
        #1;
        chk("wr_release", 160'({m0_ack, s_cyc}), 160'd0);
        tick();
        chk("wr_idle", 160'(gnt), 160'd0);

        // simultaneous requests after reset: m0 first, then m1 read
        pulse_reset();
        cyc[0] = 1; stb[0] = 1; we[0] = 1; adr[0] = 32'h4;
        cyc[1] = 1; stb[1] = 1; we[1] = 0; adr[1] = 32'h10;
        tick();
        chk("both_first", 160'(gnt), 160'h1);
        s_ack = 1;
        #1;
        chk("wait_no_ack", 160'({m0_ack, m1_ack}), 160'b10);
        tick();
        s_ack = 0; cyc[0] = 0; stb[0] = 0;
        #1;
        chk("drop_comb", 160'({gnt, s_cyc}), 160'b010);
        tick();
        chk("handover_idle", 160'(gnt), 160'd0);
        tick();
        chk("handover_m1", 160'(gnt), 160'h2);
        s_dat_i = 32'h12345678; s_ack = 1;
        #1;
        chk("m1_read", 160'({m1_dat, m1_ack, m0_dat}),
            160'({32'h12345678, 1'b1, 32'h0}));
        tick();
        s_ack = 0; s_dat_i = 0; masters_off();
        tick();

        // both masters keep requesting single-beat tenures
        drop[0] = 0; drop[1] = 0; prev_g = 2'b00;
        for (int m = 0; m < 2; m++) begin
            cyc[m] = 1; stb[m] = 1;
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            for (int m = 0; m < 2; m++) begin
                if (drop[m] == 2) begin
                    cyc[m] = 0; stb[m] = 0; drop[m] = 1;
                end else if (drop[m] == 1) begin
                    cyc[m] = 1; stb[m] = 1; drop[m] = 0;
                end
            end
            #1;
            s_ack = s_stb;
            #1;
            if (m0_ack) drop[0] = 2;
            if (m1_ack) drop[1] = 2;
            if (gnt != 2'b00 && prev_g == 2'b00) gseq.push_back(gnt);
            prev_g = gnt;
        end
        s_ack = 0; masters_off();
        tick();
        tick();
        chk("rr_count_ge4", 160'(gseq.size() >= 4), 160'd1);
        if (gseq.size() >= 4)
            chk("rr_first4", 160'({gseq[0], gseq[1], gseq[2], gseq[3]}),
                160'({2'b01, 2'b10, 2'b01, 2'b10}));
        for (int i = 1; i < gseq.size(); i++)
            chk("rr_no_repeat", 160'(gseq[i] != gseq[i-1]), 160'd1);

`ifdef WB_ARB2_WATCHDOG_EN
        // hung slave: abort after TMO unanswered strobes, m1 wins next
        pulse_reset();
        cyc[0] = 1; stb[0] = 1;
        tick();
        chk("wd_gnt", 160'(gnt), 160'h1);
        cyc[1] = 1; stb[1] = 1;
        for (int k = 0; k < TMO; k++) begin
            chk("wd_no_err_yet", 160'(m0_err), 160'd0);
            tick();
        end
        chk("wd_abort", 160'({m0_err, m1_err, s_cyc, s_stb, gnt}),
            160'({4'b1000, 2'b01}));
        tick();
        chk("wd_idle", 160'({gnt, m0_err}), 160'd0);
        tick();
        chk("wd_m1_wins", 160'(gnt), 160'h2);
        masters_off();
        tick();
        tick();
`else
        // hung slave without watchdog holds the bus indefinitely
        pulse_reset();
        cyc[0] = 1; stb[0] = 1;
        tick();
        repeat (1000) tick();
        chk("nowd_hold", 160'({s_stb, gnt, m0_err}), 160'({1'b1, 2'b01, 1'b0}));
        masters_off();
        tick();
        tick();
`endif

        // async reset while m1 owns the bus mid-transfer
        cyc[1] = 1; stb[1] = 1; adr[1] = 32'hCAFE0000;
        tick();
        chk("own1", 160'(gnt), 160'h2);
        s_dat_i = 32'hA5A5A5A5; s_ack = 1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_zero", 160'(act_vec), 160'd0);
        s_ack = 0; s_dat_i = 0;
        cyc[0] = 1; stb[0] = 1;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
        chk("post_rst_m0", 160'(gnt), 160'h1);
        masters_off();
        tick();
        tick();

        // random traffic checked against the model every cycle
        for (int i = 0; i < 3000; i++) begin
            tick();
            for (int m = 0; m < 2; m++) begin
                if ($urandom_range(0, 5) == 0) cyc[m] = ~cyc[m];
                stb[m]  = cyc[m] & ($urandom_range(0, 3) != 0);
                we[m]   = 1'($urandom_range(0, 1));
                sel[m]  = 4'($urandom);
                adr[m]  = $urandom;
                wdat[m] = $urandom;
            end
            s_dat_i = $urandom;
            s_ack = (i < 1500) ? ($urandom_range(0, 3) == 0)
                               : ($urandom_range(0, 11) == 0);
            s_err = ($urandom_range(0, 15) == 0);
        end
        masters_off();
        s_ack = 0; s_err = 0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
